systolic_seq: RTL and testbench
===============================

Name: systolic_seq

Overview:
Job sequencer for the N x N output-stationary systolic multiply array. It accepts a full A and B matrix pair through a valid/ready handshake and clears the array accumulators. It then streams skewed row and column vectors into the array's edge inputs, waits for the pipeline to drain, and captures the array's C outputs into a held result register with valid/ready output. It sits between the matrix-load logic and the array instance, and drives all of the array's control pins.

Parameters:
W, 16, element width in bits (A, B and C elements)
N, 3, array dimension; matrices are N x N
PE_LAT, 1, cycles from the last PE input to its accumulator being visible on the C output

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  job request; A, B and mode are valid
o_ready  out  1  sequencer can accept a job (high only in IDLE)
i_mode  in  1  PE mode for the job; latched on accept
i_A  in  W*N*N  matrix A; element (r,k) at bits [(r*N+k)*W +: W]
i_B  in  W*N*N  matrix B; element (k,c) at bits [(k*N+c)*W +: W]
o_valid  out  1  result held in o_C
i_ready  in  1  consumer accepts the result
o_C  out  W*N*N  result; element (r,c) at [(r*N+c)*W +: W]
o_busy  out  1  high in any state other than IDLE
o_sa_rst  out  1  array accumulator clear; connects to the array reset
o_sa_en  out  1  array enable
o_sa_mode  out  1  array mode
o_sa_A  out  W*N  row feed; slice r drives array row r
o_sa_B  out  W*N  column feed; slice c drives array column c
i_sa_C  in  W*N*N  array C outputs, same packing as o_C

Behaviour:
- Reset (asynchronous) forces:
  - state to IDLE
  - o_valid, o_sa_en, o_sa_mode, o_sa_A, o_sa_B and o_C to 0
  - the A/B holding registers to 0
- o_sa_rst = i_rst OR (state == CLEAR). The array therefore clears whenever the sequencer resets.
- o_ready = (state == IDLE). o_busy = !o_ready.
- Accept: when i_valid && o_ready at a rising edge, the block latches i_A, i_B and i_mode and moves to CLEAR. i_valid in any other state is ignored and no job is queued.
- States, each lasting the given number of cycles:
  - IDLE: en=0; feeds are 0.
  - CLEAR (1 cycle): o_sa_rst=1; en=0; feeds are 0.
  - FEED (3N-2 cycles, feed counter t = 0..3N-3): en=1.
    - o_sa_A slice r = A[r][t-r] if 0 <= t-r <= N-1, else 0.
    - o_sa_B slice c = B[t-c][c] if 0 <= t-c <= N-1, else 0.
  - DRAIN (PE_LAT cycles): en=1; feeds are 0.
  - CAPTURE (1 cycle): en=0; o_C <= i_sa_C at the end of the cycle; o_valid <= 1.
  - DONE: o_valid=1; o_C is held stable; en=0. On i_ready the block clears o_valid and returns to IDLE.
- Feed and enable outputs are registered. The values listed for a state are the values on the pins during that state's cycles.
- o_sa_mode carries the latched i_mode from CLEAR through DONE. It holds its last value in IDLE.
- Latency: o_valid rises on the 3N+PE_LAT-th rising edge after the accept edge (10 for the defaults).
- o_C keeps the previous result after the handshake until the next CAPTURE.
- Arithmetic is done in the array. The block does not modify C; overflow wraps modulo 2^W inside the PEs.
- A handshake in DONE returns the block to IDLE. A new job cannot be accepted in the same cycle; it is accepted no earlier than the next cycle.
- Reset mid-job: the job is abandoned with no output and the array is cleared through o_sa_rst. After reset release, o_ready=1 on the first cycle.

Test Plan:
- Defaults, A = [[1,2,3],[4,5,6],[7,8,9]], B = [[9,8,7],[6,5,4],[3,2,1]] -> o_C = [[30,24,18],[84,69,54],[138,114,90]]; o_valid high exactly 10 edges after accept; o_sa_en high for 8 cycles.
- A = identity, B = [[1..9]] row-major -> o_C equals B. Check the skew: at FEED t=2, o_sa_A = {A[2][0], A[1][1], A[0][2]} = {0,1,0}.
- Back-to-back jobs, all-ones A and B, then A = 2*I, B = all 3s -> first result all 3s, second all 6s. Check that the second job's CLEAR removes the first job's accumulation.
- Back-pressure: i_ready held low 20 cycles after o_valid -> o_C stable; o_ready=0; i_valid pulses ignored. Raising i_ready returns the block to IDLE and o_ready=1 on the next cycle.
- Assert i_rst during FEED t=3 -> all outputs 0 and o_sa_rst=1 during reset; after release o_valid stays 0. A new job then gives the correct result.
- Overflow: W=16, all A = 0x0100, all B = 0x0100 -> each C = 3*0x10000 mod 2^16 = 0x0000.

Source files
------------

// File: rtl/systolic_seq.sv
// rtl/systolic_seq.sv - job sequencer for an N x N output-stationary systolic multiply array
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid/o_ready       job handshake; i_A, i_B, i_mode sampled on accept
//   o_valid/i_ready       result handshake; o_C holds the captured result
//   o_busy                high whenever the sequencer is not idle
//   o_sa_rst/en/mode      array control pins
//   o_sa_A, o_sa_B        skewed row/column edge feeds into the array
//   i_sa_C                array accumulator outputs
module systolic_seq #(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int PE_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_mode,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W*N*N-1:0] o_C,
    output logic             o_busy,
    output logic             o_sa_rst,
    output logic             o_sa_en,
    output logic             o_sa_mode,
    output logic [W*N-1:0]   o_sa_A,
    output logic [W*N-1:0]   o_sa_B,
    input  logic [W*N*N-1:0] i_sa_C
);

    localparam int TW = $clog2(3*N + PE_LAT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(3*N - 3);
    localparam logic [TW-1:0] D_LAST = TW'((PE_LAT > 0) ? PE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      t_q, t_d;
    logic               valid_q, valid_d;
    logic               en_q, en_d;
    logic               mode_q;
    logic [W*N-1:0]     feed_a_q, feed_a_d;
    logic [W*N-1:0]     feed_b_q, feed_b_d;
    logic [W*N*N-1:0]   hold_a_q, hold_b_q;
    logic [W*N*N-1:0]   c_q;
    logic               accept;

    assign accept    = i_valid && (state_q == S_IDLE);
    assign o_ready   = (state_q == S_IDLE);
    assign o_busy    = (state_q != S_IDLE);
    assign o_sa_rst  = i_rst | (state_q == S_CLEAR);
    assign o_valid   = valid_q;
    assign o_C       = c_q;
    assign o_sa_en   = en_q;
    assign o_sa_mode = mode_q;
    assign o_sa_A    = feed_a_q;
    assign o_sa_B    = feed_b_q;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE:    if (i_valid) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    state_d = (PE_LAT > 0) ? S_DRAIN : S_CAPTURE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (t_q == D_LAST) begin
                    t_d     = '0;
                    state_d = S_CAPTURE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
                valid_d = 1'b1;
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Feeds and enable are registered, so they are derived from the next
    // state and next feed index; that way the pins show the values that
    // belong to the state being entered.
    always_comb begin
        int k;
        k        = 0;
        en_d     = (state_d == S_FEED) || (state_d == S_DRAIN);
        feed_a_d = '0;
        feed_b_d = '0;
        if (state_d == S_FEED) begin
            for (int r = 0; r < N; r++) begin
                k = int'(t_d) - r;
                if (k >= 0 && k < N) begin
                    feed_a_d[r*W +: W] = hold_a_q[(r*N + k)*W +: W];
                    feed_b_d[r*W +: W] = hold_b_q[(k*N + r)*W +: W];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            valid_q  <= 1'b0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            feed_a_q <= '0;
            feed_b_q <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            valid_q  <= valid_d;
            en_q     <= en_d;
            feed_a_q <= feed_a_d;
            feed_b_q <= feed_b_d;
            if (accept) begin
                hold_a_q <= i_A;
                hold_b_q <= i_B;
                mode_q   <= i_mode;
            end
            if (state_q == S_CAPTURE) c_q <= i_sa_C;
        end
    end

endmodule

// File: tb/tb_systolic_seq.sv
// tb/tb_systolic_seq.sv - directed bench for systolic_seq with a behavioural 3x3 array attached
module tb_systolic_seq;

    localparam int W = 16;
    localparam int N = 3;
    localparam int MW = W*N*N;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_mode, i_ready;
    logic [MW-1:0] i_A, i_B;
    logic          o_ready, o_valid, o_busy;
    logic          o_sa_rst, o_sa_en, o_sa_mode;
    logic [MW-1:0] o_C, sa_C;
    logic [W*N-1:0] o_sa_A, o_sa_B;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_seq #(.W(W), .N(N), .PE_LAT(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_mode(i_mode), .i_A(i_A), .i_B(i_B), .o_valid(o_valid),
        .i_ready(i_ready), .o_C(o_C), .o_busy(o_busy), .o_sa_rst(o_sa_rst),
        .o_sa_en(o_sa_en), .o_sa_mode(o_sa_mode), .o_sa_A(o_sa_A),
        .o_sa_B(o_sa_B), .i_sa_C(sa_C)
    );

    // Output-stationary array: A moves right, B moves down, one register per hop.
    logic [W-1:0] acc [N][N];
    logic [W-1:0] ar  [N][N];
    logic [W-1:0] br  [N][N];

    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [W-1:0] a_in, b_in;
                a_in = (c == 0) ? o_sa_A[r*W +: W] : ar[r][c-1];
                b_in = (r == 0) ? o_sa_B[c*W +: W] : br[r-1][c];
                if (o_sa_rst) begin
                    acc[r][c] <= '0;
                    ar[r][c]  <= '0;
                    br[r][c]  <= '0;
                end else if (o_sa_en) begin
                    acc[r][c] <= acc[r][c] + a_in * b_in;
                    ar[r][c]  <= a_in;
                    br[r][c]  <= b_in;
                end
            end
        end
    end

    always_comb begin
        sa_C = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                sa_C[(r*N + c)*W +: W] = acc[r][c];
    end

    function automatic logic [MW-1:0] mat(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {16'(e8), 16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    task automatic check(input string tag, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic start_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic m);
        @(negedge clk);
        i_valid = 1'b1; i_A = a; i_B = b; i_mode = m;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int en_cyc,
                               output logic [W*N-1:0] fa2, output logic [W*N-1:0] fb2);
        lat = 0; en_cyc = 0; fa2 = '0; fb2 = '0;
        while (!o_valid && lat < 50) begin
            if (o_sa_en) en_cyc++;
            @(posedge clk); lat++; #1;
            if (lat == 3) begin fa2 = o_sa_A; fb2 = o_sa_B; end
        end
    endtask

    task automatic handshake;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    logic [MW-1:0]  c1, id3, b19, ones, threes, twoi, sixes, hex100;
    logic [MW-1:0]  c_ref;
    logic [W*N-1:0] fa2, fb2;
    int lat, en_cyc, bp_err, v_err;

    initial begin
        c1     = mat(30, 24, 18, 84, 69, 54, 138, 114, 90);
        id3    = mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
        b19    = mat(1, 2, 3, 4, 5, 6, 7, 8, 9);
        ones   = mat(1, 1, 1, 1, 1, 1, 1, 1, 1);
        threes = mat(3, 3, 3, 3, 3, 3, 3, 3, 3);
        twoi   = mat(2, 0, 0, 0, 2, 0, 0, 0, 2);
        sixes  = mat(6, 6, 6, 6, 6, 6, 6, 6, 6);
        hex100 = mat(256, 256, 256, 256, 256, 256, 256, 256, 256);

        rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_ready = 1'b0;
        i_A = '0; i_B = '0;
        #1;
        check("rst_ready", o_ready, 1'b1);
        check("rst_sa_rst", o_sa_rst, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_C", o_C, '0);
        check("rst_en", o_sa_en, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1 check("post_rst_sa_rst", o_sa_rst, 1'b0);

        // Job 1: reference product, latency and enable length
        start_job(b19, mat(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b1);
        check("clear_sa_rst", o_sa_rst, 1'b1);
        check("clear_busy", o_busy, 1'b1);
        check("clear_ready", o_ready, 1'b0);
        wait_result(lat, en_cyc, fa2, fb2);
        check("j1_latency", lat, 10);
        check("j1_en_cycles", en_cyc, 8);
        check("j1_C", o_C, c1);
        check("j1_mode", o_sa_mode, 1'b1);
        handshake();
        check("j1_hs_valid", o_valid, 1'b0);
        check("j1_hs_ready", o_ready, 1'b1);
        check("j1_C_held", o_C, c1);

        // Job 2: identity times B, plus feed skew at t=2
        start_job(id3, b19, 1'b0);
        wait_result(lat, en_cyc, fa2, fb2);
        check("j2_skew_A", fa2, {16'd0, 16'd1, 16'd0});
        check("j2_skew_B", fb2, {16'd3, 16'd5, 16'd7});
        check("j2_latency", lat, 10);
        check("j2_C", o_C, b19);
        check("j2_mode", o_sa_mode, 1'b0);
        handshake();

        // Back-to-back: ones x ones, then 2I x 3s with i_valid already high at handshake
        start_job(ones, ones, 1'b0);
        wait_result(lat, en_cyc, fa2, fb2);
        check("bb1_C", o_C, threes);
        i_ready = 1'b1; i_valid = 1'b1; i_A = twoi; i_B = threes;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("bb_no_same_cycle", o_ready, 1'b1);
        check("bb_valid_low", o_valid, 1'b0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("bb2_accepted", o_busy, 1'b1);
        wait_result(lat, en_cyc, fa2, fb2);
        check("bb2_latency", lat, 10);
        check("bb2_C", o_C, sixes);

        // Back-pressure on the held result
        bp_err = 0;
        c_ref  = o_C;
        for (int i = 0; i < 20; i++) begin
            i_valid = (i % 2 == 0); i_A = ones; i_B = ones;
            @(posedge clk); #1;
            if (o_C !== c_ref || o_ready !== 1'b0 || o_valid !== 1'b1) bp_err++;
        end
        i_valid = 1'b0;
        check("bp_stable", bp_err, 0);
        check("bp_C", o_C, sixes);
        handshake();
        check("bp_release_ready", o_ready, 1'b1);

        // Reset during FEED t=3
        start_job(ones, ones, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_sa_rst", o_sa_rst, 1'b1);
        check("mid_rst_en", o_sa_en, 1'b0);
        check("mid_rst_feeds", {o_sa_A, o_sa_B}, '0);
        check("mid_rst_C", o_C, '0);
        check("mid_rst_mode", o_sa_mode, 1'b0);
        check("mid_rst_valid", o_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1 check("mid_rst_ready", o_ready, 1'b1);
        v_err = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b0) v_err++;
        end
        check("mid_rst_no_result", v_err, 0);
        start_job(b19, mat(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b0);
        wait_result(lat, en_cyc, fa2, fb2);
        check("after_rst_C", o_C, c1);
        handshake();

        // Overflow wraps inside the PEs
        start_job(hex100, hex100, 1'b0);
        wait_result(lat, en_cyc, fa2, fb2);
        check("ovf_latency", lat, 10);
        check("ovf_C", o_C, '0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
